// File: rtl/tt_sweep_pkg.sv
// Shared types for the truth-table sweeper: FSM state, 8-bit truth table, row-to-bit mapping.
package tt_sweep_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t;
  typedef logic [7:0] truth_table_t;

  localparam truth_table_t TT_0x7C = 8'h7C;

  // Row {in1,in2,in3} lands at bit 7-row, so row 000 is the MSB of the hex table.
  function automatic logic [2:0] tt_bit(input logic [2:0] row);
    return 3'd7 - row;
  endfunction
endpackage

// File: rtl/truth_table_sweeper_sync2.sv
// Two-flop synchroniser for the asynchronous gate output; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 input rows, samples each after a settle time and
// compares the captured table with the expected one. STABILITY_CHECK_EN adds per-row glitch flags.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int STABLE_WINDOW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  truth_table_t expected,
  input  logic         gate_out,
  output logic [2:0]   gate_in,
  output logic         busy,
  output logic         done,
  output truth_table_t measured,
  output logic         match,
  output logic         result_valid
`ifdef STABILITY_CHECK_EN
  ,
  output truth_table_t unstable
`endif
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || STABLE_WINDOW < 1 || STABLE_WINDOW > SETTLE_CYCLES) begin : g_param_err
    $error("truth_table_sweeper: need 1 <= STABLE_WINDOW <= SETTLE_CYCLES");
  end

  sweep_state_t     state_q, state_d;
  logic [2:0]       row_q, row_d, gate_in_q, gate_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, match_q, match_d, rv_q, rv_d;
  truth_table_t     measured_q, measured_d, exp_q, exp_d;
  logic             gate_s;
  logic             clean;

  sync2 u_sync (.clk(clk), .rst(rst), .d(gate_out), .q(gate_s));

`ifdef STABILITY_CHECK_EN
  localparam logic [CNT_W-1:0] WIN_FIRST = CNT_W'(SETTLE_CYCLES - STABLE_WINDOW);
  truth_table_t unstable_q, unstable_d;
  logic         gate_prev_q;
  assign clean = (unstable_q == '0);
`else
  assign clean = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    gate_in_d  = gate_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    measured_d = measured_q;
    match_d    = match_q;
    rv_d       = rv_q;
    exp_d      = exp_q;
`ifdef STABILITY_CHECK_EN
    unstable_d = unstable_q;
`endif
    case (state_q)
      IDLE: if (start && !abort) begin
        exp_d      = expected;
        row_d      = '0;
        gate_in_d  = '0;
        cnt_d      = '0;
        rv_d       = 1'b0;
        measured_d = '0;
        busy_d     = 1'b1;
`ifdef STABILITY_CHECK_EN
        unstable_d = '0;
`endif
        state_d    = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
`ifdef STABILITY_CHECK_EN
        // Only changes between consecutive window cycles count; the synchroniser's
        // arrival of a new row value just before the window is expected.
        if (cnt_q > WIN_FIRST && gate_s != gate_prev_q) unstable_d[tt_bit(row_q)] = 1'b1;
`endif
      end
      SAMPLE: begin
        measured_d[tt_bit(row_q)] = gate_s;
        if (row_q == 3'd7) begin
          state_d = DONE;
        end else begin
          row_d     = row_q + 3'd1;
          gate_in_d = row_q + 3'd1;
          cnt_d     = '0;
          state_d   = SETTLE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        rv_d    = 1'b1;
        match_d = (measured_q == exp_q) && clean;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && abort) begin
      state_d    = IDLE;
      gate_in_d  = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      rv_d       = 1'b0;
      match_d    = match_q;
      measured_d = measured_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      cnt_q      <= '0;
      gate_in_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      measured_q <= '0;
      match_q    <= 1'b0;
      rv_q       <= 1'b0;
      exp_q      <= '0;
`ifdef STABILITY_CHECK_EN
      unstable_q  <= '0;
      gate_prev_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      gate_in_q  <= gate_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      measured_q <= measured_d;
      match_q    <= match_d;
      rv_q       <= rv_d;
      exp_q      <= exp_d;
`ifdef STABILITY_CHECK_EN
      unstable_q  <= unstable_d;
      gate_prev_q <= gate_s;
`endif
    end
  end

  assign gate_in      = gate_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign measured     = measured_q;
  assign match        = match_q;
  assign result_valid = rv_q;
`ifdef STABILITY_CHECK_EN
  assign unstable     = unstable_q;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised bench for truth_table_sweeper against a timing/table reference model.
module tb_truth_table_sweeper;
  import tt_sweep_pkg::*;

  localparam int S   = 4;
  localparam int LAT = 8 * (S + 1) + 1;

  logic         clk = 1'b0;
  logic         rst, start, abort, gate_out, glitch;
  truth_table_t expected, gt;
  logic [2:0]   gate_in;
  logic         busy, done, match, result_valid;
  truth_table_t measured;
`ifdef STABILITY_CHECK_EN
  truth_table_t unstable;
`endif

  int n_chk = 0;
  int n_pass = 0;

  truth_table_sweeper #(.SETTLE_CYCLES(S), .STABLE_WINDOW(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .gate_out(gate_out), .gate_in(gate_in), .busy(busy), .done(done),
    .measured(measured), .match(match), .result_valid(result_valid)
`ifdef STABILITY_CHECK_EN
    , .unstable(unstable)
`endif
  );

  always #5 clk = ~clk;

  // Gate under test: a static truth table in the team's bit order, plus an optional glitch.
  assign gate_out = gt[3'd7 - gate_in] ^ glitch;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input truth_table_t e);
    start    = 1'b1;
    expected = e;
    tick();
    start    = 1'b0;
    expected = truth_table_t'($urandom);
    chk("busy_on_start", 32'(busy), 32'd1);
    chk("rv_clr_on_start", 32'(result_valid), 32'd0);
    chk("gate_in_row0", 32'(gate_in), 32'd0);
  endtask

  // Full sweep; restart_at > 0 pulses a (to-be-ignored) start with a different table.
  task automatic run_sweep(input truth_table_t g, input truth_table_t e, input int restart_at);
    int ndone = 0;
    int r;
    gt = g;
    start_sweep(e);
    for (int t = 1; t <= LAT + 2; t++) begin
      if (t == restart_at) begin
        start    = 1'b1;
        expected = ~e;
      end
      tick();
      start = 1'b0;
      r = t / (S + 1);
      if (r > 7) r = 7;
      chk("gate_in", 32'(gate_in), 32'(r));
      chk("busy", 32'(busy), 32'(t < LAT));
      chk("done", 32'(done), 32'(t == LAT));
      if (done) ndone++;
      if (t == LAT) begin
        chk("measured", 32'(measured), 32'(g));
        chk("match", 32'(match), 32'(g == e));
        chk("result_valid", 32'(result_valid), 32'd1);
`ifdef STABILITY_CHECK_EN
        chk("unstable_clean", 32'(unstable), 32'd0);
`endif
      end
    end
    chk("done_count", 32'(ndone), 32'd1);
  endtask

  initial begin
    truth_table_t g, e;
    int ndone;
    rst = 1'b1; start = 1'b0; abort = 1'b0; glitch = 1'b0;
    expected = '0; gt = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gate_in", 32'(gate_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_measured", 32'(measured), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    rst = 1'b0;
    tick();

    // T1, T2, T3
    run_sweep(TT_0x7C, TT_0x7C, -1);
    run_sweep(TT_0x7C, 8'h3E, -1);
    run_sweep(TT_0x7C, 8'h3E, 10);

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", 32'(busy), 32'd0);
    chk("start_abort_idle_rv", 32'(result_valid), 32'd1);

    // T4: abort during row 3
    gt = truth_table_t'($urandom);
    start_sweep(gt);
    for (int t = 1; t <= 17; t++) begin
      if (t == 17) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_gate_in", 32'(gate_in), 32'd0);
    chk("abort_rv", 32'(result_valid), 32'd0);
    ndone = 0;
    for (int t = 0; t < LAT + 4; t++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_rv_stays", 32'(result_valid), 32'd0);
    run_sweep(TT_0x7C, TT_0x7C, -1);

    // T5: asynchronous reset during row 5 settle
    gt = TT_0x7C;
    start_sweep(TT_0x7C);
    for (int t = 1; t <= 27; t++) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_gate_in", 32'(gate_in), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_measured", 32'(measured), 32'd0);
    chk("arst_match", 32'(match), 32'd0);
    chk("arst_rv", 32'(result_valid), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("arst_idle_busy", 32'(busy), 32'd0);
    end
    chk("arst_idle_gate_in", 32'(gate_in), 32'd0);

    // random tables, roughly half matching
    for (int k = 0; k < 6; k++) begin
      g = truth_table_t'($urandom);
      e = ($urandom_range(0, 1) == 1) ? g : truth_table_t'($urandom);
      run_sweep(g, e, (k == 0) ? 23 : -1);
    end

`ifdef STABILITY_CHECK_EN
    // T6: one-cycle glitch that reaches the synchronised output in row 2's last settle cycle
    gt = TT_0x7C;
    start_sweep(TT_0x7C);
    for (int t = 1; t <= LAT; t++) begin
      tick();
      if (t == 11) glitch = 1'b1;
      if (t == 12) glitch = 1'b0;
    end
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_unstable", 32'(unstable), 32'h20);
    chk("t6_measured", 32'(measured), 32'h7C);
    chk("t6_match", 32'(match), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
